// File: rtl/booth_radix4_mul.sv
// booth_radix4_mul
// Iterative radix-4 Booth multiplier. It retires two multiplier bits per
// cycle and decodes the RV32M multiply flavours (MUL, MULH, MULHSU, MULHU).
// A request is accepted only while idle and not flushed. The full product
// and the architectural result are registered on completion and hold their
// value until the next completion.
//
// Ports
//   i_clk      rising-edge clock
//   i_rst_n    synchronous active-low reset
//   i_start    request, accepted when o_busy=0 and i_flush=0
//   i_op       00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (sampled with i_start)
//   i_x        multiplier rs1 (sampled with i_start)
//   i_y        multiplicand rs2 (sampled with i_start)
//   i_flush    abort the in-flight operation
//   o_busy     operation in flight
//   o_valid    one-cycle pulse when o_z / o_result are final
//   o_z        full 2*XLEN product
//   o_result   low word for MUL, high word otherwise
module booth_radix4_mul #(
    parameter int XLEN = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [1:0]          i_op,
    input  logic [XLEN-1:0]     i_x,
    input  logic [XLEN-1:0]     i_y,
    input  logic                i_flush,
    output logic                o_busy,
    output logic                o_valid,
    output logic [2*XLEN-1:0]   o_z,
    output logic [XLEN-1:0]     o_result
);

    // Extended operand width: even, and wide enough for an unsigned MSB and +-2Y.
    localparam int EW   = XLEN + 2;
    localparam int N    = XLEN / 2 + 1;
    localparam int CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_MULHU = 2'b11;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [1:0]            r_op;
    logic signed [EW-1:0]  r_y;
    // {partial sum (EW), extended X (EW), x[-1]}
    logic [2*EW:0]         r_acc;
    logic                  r_busy;
    logic                  r_valid;
    logic [2*XLEN-1:0]     r_z;
    logic [XLEN-1:0]       r_result;

    logic signed [EW:0]    w_ps;
    logic signed [EW:0]    w_sum;
    logic [2*EW:0]         w_next;
    logic [2*XLEN-1:0]     w_z;
    logic [EW-1:0]         w_x_ext;
    logic signed [EW-1:0]  w_y_ext;

    // Booth partial-product select from the current bit triplet.
    function automatic logic signed [EW:0] booth_pp(
        input logic [2:0]           trip,
        input logic signed [EW-1:0] y
    );
        logic signed [EW:0] y1;
        logic signed [EW:0] y2;
        y1 = {y[EW-1], y};
        y2 = y1 <<< 1;
        case (trip)
            3'b001, 3'b010: return y1;
            3'b011:         return y2;
            3'b100:         return -y2;
            3'b101, 3'b110: return -y1;
            default:        return '0;
        endcase
    endfunction

    // X is unsigned only for MULHU; Y is signed only for MUL and MULH.
    always_comb begin
        w_x_ext = (i_op == OP_MULHU) ? {2'b00, i_x} : {{2{i_x[XLEN-1]}}, i_x};
        w_y_ext = (i_op == OP_MUL || i_op == OP_MULH) ?
                  $signed({{2{i_y[XLEN-1]}}, i_y}) : $signed({2'b00, i_y});
    end

    // One extra sum bit absorbs the add before the arithmetic shift by 2;
    // the dropped top bit is a redundant sign copy after the shift.
    always_comb begin
        w_ps   = $signed({r_acc[2*EW], r_acc[2*EW:EW+1]});
        w_sum  = w_ps + booth_pp(r_acc[2:0], r_y);
        w_next = {w_sum[EW], w_sum, r_acc[EW:2]};
        w_z    = w_next[2*XLEN:1];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_z      <= '0;
            r_result <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_flush) begin
                        r_op    <= i_op;
                        r_y     <= w_y_ext;
                        r_acc   <= {{EW{1'b0}}, w_x_ext, 1'b0};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_flush) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == LAST) begin
                            r_z      <= w_z;
                            r_result <= (r_op == OP_MUL) ? w_z[XLEN-1:0] : w_z[2*XLEN-1:XLEN];
                            r_valid  <= 1'b1;
                            r_busy   <= 1'b0;
                            r_state  <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_valid  = r_valid;
    assign o_z      = r_z;
    assign o_result = r_result;

endmodule

// File: doc/booth_radix4_mul.md
# booth_radix4_mul

Parametrised, iterative radix-4 Booth multiplier for the ALU operations group, the next generation of the core's radix-2 sequential multiplier. It retires two multiplier bits per cycle and natively decodes the four RV32M multiply flavours (MUL, MULH, MULHSU, MULHU). It adds a busy/flush handshake so the issue stage can abort on pipeline kill, and it accepts back-to-back operations. The result is returned both as the full 2·XLEN product and as the XLEN-bit architectural result selected by the operation.

## Interface
- XLEN, default core_config_pkg::XLEN (32): operand width; must be even and at least 8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  request; accepted only when busy=0 and flush=0.
- op  in  2  sampled with start: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- X  in  XLEN  multiplier (rs1); scanned two bits per cycle; sampled with start.
- Y  in  XLEN  multiplicand (rs2); sampled with start.
- flush  in  1  abort the in-flight operation.
- busy  out  1  high while an operation is in flight.
- valid  out  1  one-cycle pulse when Z and result are final.
- Z  out  2·XLEN  full product.
- result  out  XLEN  Z[XLEN-1:0] for MUL; Z[2·XLEN-1:XLEN] for all other ops.

## Operation
- **Signedness.** X is signed for MUL, MULH and MULHSU; Y is signed for MUL and MULH. The MUL low word is independent of signedness.
- **Operand extension.**
  - X is extended by 2 bits (sign-extended or zero-extended) to XLEN+2 bits, so the width is even and an unsigned MSB is covered. This gives N = XLEN/2+1 iterations.
  - Y is extended to XLEN+2 bits, so that ±2Y fits without overflow.
- **Datapath.**
  - The accumulator/shift register is 2·XLEN+4 bits: upper XLEN+2 bits are the partial sum, lower XLEN+2 bits are extended X, plus an implicit bit x[-1]=0.
  - Each iteration inspects the triplet {x[2i+1], x[2i], x[2i-1]}:
    - 000 or 111: add 0.
    - 001 or 010: add +Y.
    - 011: add +2Y.
    - 100: add −2Y.
    - 101 or 110: add −Y.
  - After the add, the register is shifted arithmetically right by 2.
- **Finalisation.** After N iterations, the low 2·XLEN bits of the register form Z. They are registered into Z/result.
- **FSM: IDLE → RUN → IDLE.**
  - IDLE: on a start that is accepted, load the operands, clear the iteration counter, set busy, and go to RUN.
  - RUN: perform one iteration per cycle.
    - At counter N−1: write Z/result, pulse valid, clear busy, return to IDLE.
    - If flush=1: return to IDLE immediately. Clear busy, do not pulse valid, and leave Z/result untouched.
- **Output hold.** Z and result hold their last completed value until the next completion. They are never updated on flush or on an accept.
- **Start while busy.** Ignored; no queueing.
- **Simultaneous start and flush in IDLE.** flush wins; the request is not accepted.
- **Back-to-back.** start in the valid cycle is accepted, because busy is already 0.
- **Reset** (including mid-operation): all state is cleared on the next clk edge with rst_n=0. The FSM returns to IDLE and no valid pulse is produced.

## Timing
- **Reset values:** busy=0, valid=0, Z=0, result=0, FSM in IDLE.
- **Latency.** Let start be accepted at edge E0.
  - busy=1 after E0.
  - Iterations occur on edges E1..EN.
  - After EN: valid=1 for exactly one cycle, busy=0, Z/result are valid.
  - For XLEN=32, N=17 cycles from accept to valid.
- **Throughput:** one operation every N cycles.
- **Flush.** flush=1 at edge Ek (1≤k≤N) gives busy=0 and valid=0 after Ek.
- **Output timing.** valid and busy are registered, with no combinational path from the inputs. result is a registered mux selected by the op latched at accept.
- **Critical path:** one (XLEN+3)-bit add/sub with a 2:1 ±Y/±2Y select.

## Test plan
1. MUL, X=7, Y=0xFFFFFFFD → valid exactly 17 cycles after the accept edge; result=0xFFFFFFEB; Z=0xFFFFFFFFFFFFFFEB; busy high for 17 cycles.
2. MULHU, X=Y=0xFFFFFFFF → Z=0xFFFFFFFE00000001, result=0xFFFFFFFE. Same operands with MULH → Z=0x0000000000000001, result=0x00000000.
3. MULH, X=Y=0x80000000 → Z=0x4000000000000000, result=0x40000000. MULHSU with X=0xFFFFFFFF, Y=0xFFFFFFFF → Z=0xFFFFFFFF00000001, result=0xFFFFFFFF.
4. Start MUL 3×5, flush at the 5th RUN cycle, with start held high throughout → busy=0 the next cycle, no valid pulse, Z/result keep their prior value. Issue MUL 6×9 → result=54.
5. Start 2×3, then assert start with 4×4 during RUN → second request ignored, result=6. Assert start with 4×4 in the valid cycle → accepted, result=16 exactly 17 cycles later.
6. Assert rst_n=0 for one cycle at iteration 8 → busy=0, valid=0, Z=0, result=0 next cycle, no stray valid afterwards. Drive random signed/unsigned vectors for all four ops (including 0, 1, −1, MIN) against a reference model, also at XLEN=16 and XLEN=64.
